wash_control: RTL and testbench

WASH_CONTROL -- requirements
Module: wash_control

---
 rtl/wash_control_pkg.sv | 66 ++++++
 rtl/wash_control_if.sv | 22 ++
 rtl/wash_control_bcd.sv | 28 ++
 rtl/wash_control.sv | 154 +++++++++++++++
 tb/tb_wash_control.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/wash_control_pkg.sv
// Shared definitions for the washing-machine controller: state codes, LED bit
// positions, phase timing, and per-mode phase masks and BCD run totals.
package wash_control_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_BEGIN = 3'd1,
        ST_SET   = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4,
        ST_PAUSE = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    localparam int D_SET_LED     = 9;
    localparam int D_PWR_LED     = 8;
    localparam int D_WASH_IN     = 7;
    localparam int D_WASH        = 6;
    localparam int D_RINSE_OUT   = 5;
    localparam int D_RINSE_SPIN  = 4;
    localparam int D_RINSE_IN    = 3;
    localparam int D_RINSE       = 2;
    localparam int D_DRY_OUT     = 1;
    localparam int D_DRY_SPIN    = 0;

    localparam logic [2:0] MODE_LAST = 3'd4;

    function automatic logic [3:0] phase_dur(input logic [2:0] idx);
        case (idx)
            3'd6:       return 4'd9;
            3'd2, 3'd0: return 4'd6;
            default:    return 4'd3;
        endcase
    endfunction

    function automatic logic [7:0] mode_mask(input logic [2:0] m);
        case (m)
            3'd1:    return 8'hC0;
            3'd2:    return 8'hFC;
            3'd3:    return 8'h3F;
            3'd4:    return 8'h03;
            default: return 8'hFF;
        endcase
    endfunction

    // Two-digit BCD sum of the durations of every phase in the mode.
    function automatic logic [7:0] mode_total(input logic [2:0] m);
        case (m)
            3'd1:    return 8'h12;
            3'd2:    return 8'h27;
            3'd3:    return 8'h24;
            3'd4:    return 8'h09;
            default: return 8'h36;
        endcase
    endfunction

    // {found, idx}: highest phase in mask whose index is strictly below 'from'.
    function automatic logic [3:0] phase_below(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++)
            if (mask[i] && (4'(i) < from)) r = {1'b1, 3'(i)};
        return r;
    endfunction

endpackage

// File: rtl/wash_control_if.sv
// Key inputs and display/LED outputs of the wash controller.
interface wash_control_if;
    logic       tick;
    logic       powerKey;
    logic       startKey;
    logic       modeKey;
    logic       lidOpen;
    logic [2:0] state;
    logic [9:0] data;
    logic [5:0] outLeft;
    logic [5:0] outMiddle;
    logic [5:0] outRight;

    modport master (
        output tick, powerKey, startKey, modeKey, lidOpen,
        input  state, data, outLeft, outMiddle, outRight
    );
    modport slave (
        input  tick, powerKey, startKey, modeKey, lidOpen,
        output state, data, outLeft, outMiddle, outRight
    );
endinterface

// File: rtl/wash_control_bcd.sv
// Two-digit BCD down-counter with load and saturation at 00; exposes the
// value it will hold after the coming edge so callers can register outputs.
module bcd_down_counter (
    input  logic       cp,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_val,
    input  logic       i_dec,
    output logic [7:0] o_nxt
);
    logic [7:0] r_q;
    logic [7:0] w_dec_val;

    always_comb begin
        w_dec_val = r_q;
        if (r_q != 8'h00) begin
            if (r_q[3:0] == 4'd0) w_dec_val = {r_q[7:4] - 4'd1, 4'd9};
            else                  w_dec_val = {r_q[7:4], r_q[3:0] - 4'd1};
        end
        o_nxt = r_q;
        if (i_load)     o_nxt = i_val;
        else if (i_dec) o_nxt = w_dec_val;
    end

    always_ff @(posedge cp or posedge rst)
        if (rst) r_q <= 8'h00;
        else     r_q <= o_nxt;
endmodule

// File: rtl/wash_control.sv
// Washing-machine program controller: power/set/run/pause/error/finish FSM,
// phase sequencing and remaining-time display, all outputs registered.
module wash_control
    import wash_control_pkg::*;
(
    input  logic          cp,
    input  logic          rst,
    wash_control_if.slave bus
);
    state_e     r_state, w_state;
    logic [2:0] r_mode,  w_mode;
    logic [2:0] r_phase, w_phase;
    logic [3:0] r_pcnt,  w_pcnt;
    logic [1:0] r_tcnt,  w_tcnt;
    logic [9:0] r_data,  w_data;
    logic [5:0] r_left,  w_left;
    logic [5:0] r_mid,   w_mid;
    logic [5:0] r_right, w_right;
    logic       w_load, w_dec;
    logic [7:0] w_ldval, w_rem_nxt;
    logic [2:0] w_first;
    logic [3:0] w_nxt_ph;

    bcd_down_counter u_rem (
        .cp(cp), .rst(rst), .i_load(w_load), .i_val(w_ldval), .i_dec(w_dec), .o_nxt(w_rem_nxt)
    );

    // Every mode has at least one phase, so the first-phase lookup always hits.
    assign w_first  = 3'(phase_below(mode_mask(r_mode), 4'd8));
    assign w_nxt_ph = phase_below(mode_mask(r_mode), {1'b0, r_phase});

    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_phase = r_phase;
        w_pcnt  = r_pcnt;
        w_tcnt  = r_tcnt;
        w_load  = 1'b0;
        w_ldval = mode_total(r_mode);
        w_dec   = 1'b0;
        if (bus.powerKey) begin
            w_tcnt = 2'd0;
            if (r_state == ST_OFF) begin
                w_state = ST_BEGIN;
            end else begin
                w_state = ST_OFF;
                w_mode  = 3'd0;
                w_phase = 3'd0;
                w_pcnt  = 4'd0;
            end
        end else begin
            case (r_state)
                ST_BEGIN: if (bus.tick) begin
                    if (r_tcnt == 2'd1) begin
                        w_state = ST_SET;
                        w_mode  = 3'd0;
                        w_tcnt  = 2'd0;
                        w_load  = 1'b1;
                        w_ldval = mode_total(3'd0);
                    end else w_tcnt = r_tcnt + 2'd1;
                end
                ST_SET: if (bus.startKey) begin
                    // Error entry also arms the first phase so a later resume has a phase to run.
                    w_state = bus.lidOpen ? ST_ERR : ST_RUN;
                    w_phase = w_first;
                    w_pcnt  = phase_dur(w_first);
                    w_load  = 1'b1;
                end else if (bus.modeKey) begin
                    w_mode  = (r_mode == MODE_LAST) ? 3'd0 : r_mode + 3'd1;
                    w_load  = 1'b1;
                    w_ldval = mode_total(w_mode);
                end
                ST_RUN: begin
                    if (bus.lidOpen)       w_state = ST_ERR;
                    else if (bus.startKey) w_state = ST_PAUSE;
                    else if (bus.tick) begin
                        w_dec = 1'b1;
                        if (r_pcnt == 4'd1) begin
                            if (w_nxt_ph[3]) begin
                                w_phase = w_nxt_ph[2:0];
                                w_pcnt  = phase_dur(w_nxt_ph[2:0]);
                            end else begin
                                w_state = ST_FIN;
                                w_pcnt  = 4'd0;
                                w_tcnt  = 2'd0;
                            end
                        end else w_pcnt = r_pcnt - 4'd1;
                    end
                end
                ST_PAUSE: if (!bus.lidOpen && bus.startKey) w_state = ST_RUN;
                ST_ERR:   if (!bus.lidOpen) w_state = ST_PAUSE;
                ST_FIN: if (bus.tick) begin
                    if (r_tcnt == 2'd2) begin
                        w_state = ST_OFF;
                        w_tcnt  = 2'd0;
                    end else w_tcnt = r_tcnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode works on next-state values so the output flops track the state flops.
    always_comb begin
        w_data  = 10'd0;
        w_left  = 6'd0;
        w_mid   = 6'd0;
        w_right = 6'd0;
        w_data[D_PWR_LED] = (w_state != ST_OFF);
        case (w_state)
            ST_SET: begin
                w_data[D_SET_LED] = 1'b1;
                w_data[7:0]       = mode_mask(w_mode);
            end
            ST_RUN, ST_PAUSE, ST_ERR: w_data[7:0] = 8'd1 << w_phase;
            default: ;
        endcase
        if (w_state inside {ST_SET, ST_RUN, ST_PAUSE, ST_ERR}) begin
            w_left  = {3'd0, w_mode};
            w_mid   = {2'd0, w_rem_nxt[7:4]};
            w_right = {2'd0, w_rem_nxt[3:0]};
        end
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_mode  <= 3'd0;
            r_phase <= 3'd0;
            r_pcnt  <= 4'd0;
            r_tcnt  <= 2'd0;
            r_data  <= 10'd0;
            r_left  <= 6'd0;
            r_mid   <= 6'd0;
            r_right <= 6'd0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_phase <= w_phase;
            r_pcnt  <= w_pcnt;
            r_tcnt  <= w_tcnt;
            r_data  <= w_data;
            r_left  <= w_left;
            r_mid   <= w_mid;
            r_right <= w_right;
        end
    end

    assign bus.state     = r_state;
    assign bus.data      = r_data;
    assign bus.outLeft   = r_left;
    assign bus.outMiddle = r_mid;
    assign bus.outRight  = r_right;
endmodule

// File: tb/tb_wash_control.sv
// Self-checking bench for wash_control: mode table plus hand sequences for
// pause/error/power/reset corners and a full mode-0 program.
module tb_wash_control;
    logic cp = 1'b0;
    logic rst;
    logic lid = 1'b0;
    wash_control_if bus();

    wash_control dut (.cp(cp), .rst(rst), .bus(bus));

    always #5 cp = ~cp;

    typedef struct {
        logic [2:0] st;
        logic [9:0] data;
        logic [5:0] l, m, r;
    } exp_t;

    typedef struct {
        logic pk, sk, mk, tk;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;
    vec_t tv[9];

    function automatic exp_t E(input int st, input int d, input int l, input int m, input int r);
        exp_t e;
        e.st = 3'(st); e.data = 10'(d); e.l = 6'(l); e.m = 6'(m); e.r = 6'(r);
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (bus.state !== e.st || bus.data !== e.data || bus.outLeft !== e.l ||
            bus.outMiddle !== e.m || bus.outRight !== e.r) begin
            errs++;
            $display("FAIL %s: got st=%0d data=%h dig=%0d/%0d/%0d, want st=%0d data=%h dig=%0d/%0d/%0d",
                     name, bus.state, bus.data, bus.outLeft, bus.outMiddle, bus.outRight,
                     e.st, e.data, e.l, e.m, e.r);
        end
    endtask

    task automatic clr();
        bus.powerKey = 1'b0; bus.startKey = 1'b0; bus.modeKey = 1'b0; bus.tick = 1'b0;
        bus.lidOpen  = lid;
    endtask

    task automatic cyc(input string name, input logic pk, input logic sk, input logic mk,
                       input logic tk, input exp_t e);
        @(negedge cp);
        bus.powerKey = pk; bus.startKey = sk; bus.modeKey = mk; bus.tick = tk;
        bus.lidOpen  = lid;
        sb.push_back(e);
        @(posedge cp);
        #1;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty", name);
        end else compare(name, sb.pop_front());
    endtask

    task automatic power_on(input string name);
        cyc({name, "_pwr"},   1'b1, 1'b0, 1'b0, 1'b0, E(1, 'h100, 0, 0, 0));
        cyc({name, "_beg1"},  1'b0, 1'b0, 1'b0, 1'b1, E(1, 'h100, 0, 0, 0));
        cyc({name, "_beg2"},  1'b0, 1'b0, 1'b0, 1'b1, E(2, 'h3FF, 0, 3, 6));
    endtask

    initial begin
        int dur[8] = '{6, 3, 6, 3, 3, 3, 9, 3};
        int ph, pc, rem;

        lid = 1'b0;
        clr();
        rst = 1'b1;
        #12;
        compare("reset", E(0, 0, 0, 0, 0));
        @(negedge cp); rst = 1'b0;
        cyc("off_ignores_keys", 1'b0, 1'b1, 1'b1, 1'b1, E(0, 0, 0, 0, 0));

        // Mode stepping, then mode 4 (dry only) program
        power_on("m4");
        cyc("set_ignores_tick", 1'b0, 1'b0, 1'b0, 1'b1, E(2, 'h3FF, 0, 3, 6));
        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h3C0, 1, 1, 2)};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h3FC, 2, 2, 7)};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h33F, 3, 2, 4)};
        tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h303, 4, 0, 9)};
        tv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, E(3, 'h102, 4, 0, 9)};
        tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h102, 4, 0, 8)};
        tv[6] = '{1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h102, 4, 0, 7)};
        tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h101, 4, 0, 6)};
        tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, E(3, 'h101, 4, 0, 6)};
        for (int i = 0; i < 9; i++)
            cyc($sformatf("mode_tbl%0d", i), tv[i].pk, tv[i].sk, tv[i].mk, tv[i].tk, tv[i].e);
        for (int k = 1; k <= 6; k++)
            cyc($sformatf("m4_dry%0d", k), 1'b0, 1'b0, 1'b0, 1'b1,
                (k < 6) ? E(3, 'h101, 4, 0, 6 - k) : E(6, 'h100, 0, 0, 0));
        cyc("m4_fin1", 1'b0, 1'b0, 1'b0, 1'b1, E(6, 'h100, 0, 0, 0));
        cyc("m4_fin2", 1'b0, 1'b0, 1'b0, 1'b1, E(6, 'h100, 0, 0, 0));
        cyc("m4_fin3", 1'b0, 1'b0, 1'b0, 1'b1, E(0, 0, 0, 0, 0));

        // Mode 1 pause/resume and lid error
        power_on("m1");
        cyc("m1_mode",   1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h3C0, 1, 1, 2));
        cyc("m1_start",  1'b0, 1'b1, 1'b0, 1'b0, E(3, 'h180, 1, 1, 2));
        cyc("m1_t1",     1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h180, 1, 1, 1));
        cyc("m1_t2",     1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h180, 1, 1, 0));
        cyc("m1_pause",  1'b0, 1'b1, 1'b0, 1'b0, E(5, 'h180, 1, 1, 0));
        for (int k = 0; k < 5; k++)
            cyc($sformatf("m1_frozen%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, E(5, 'h180, 1, 1, 0));
        cyc("m1_resume", 1'b0, 1'b1, 1'b0, 1'b0, E(3, 'h180, 1, 1, 0));
        cyc("m1_ph6",    1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h140, 1, 0, 9));
        cyc("m1_t4",     1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h140, 1, 0, 8));
        lid = 1'b1;
        cyc("lid_err",   1'b0, 1'b0, 1'b0, 1'b0, E(4, 'h140, 1, 0, 8));
        cyc("err_tick",  1'b0, 1'b0, 1'b0, 1'b1, E(4, 'h140, 1, 0, 8));
        cyc("err_start", 1'b0, 1'b1, 1'b0, 1'b1, E(4, 'h140, 1, 0, 8));
        lid = 1'b0;
        cyc("err_pause", 1'b0, 1'b0, 1'b0, 1'b0, E(5, 'h140, 1, 0, 8));
        cyc("err_resume",1'b0, 1'b1, 1'b0, 1'b0, E(3, 'h140, 1, 0, 8));
        cyc("err_tick2", 1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h140, 1, 0, 7));
        lid = 1'b1;
        cyc("pwr_lid",   1'b1, 1'b0, 1'b0, 1'b0, E(0, 0, 0, 0, 0));
        lid = 1'b0;

        // Start from set with lid open, then priority corners
        power_on("se");
        lid = 1'b1;
        cyc("set_err",     1'b0, 1'b1, 1'b0, 1'b0, E(4, 'h180, 0, 3, 6));
        lid = 1'b0;
        cyc("set_err_pse", 1'b0, 1'b0, 1'b0, 1'b0, E(5, 'h180, 0, 3, 6));
        cyc("pse_run",     1'b0, 1'b1, 1'b1, 1'b0, E(3, 'h180, 0, 3, 6));
        cyc("start_gt_tk", 1'b0, 1'b1, 1'b0, 1'b1, E(5, 'h180, 0, 3, 6));
        cyc("pse_pwr",     1'b1, 1'b0, 1'b0, 1'b0, E(0, 0, 0, 0, 0));

        // Full mode 0 program; start beats mode in set
        power_on("m0");
        cyc("m0_start", 1'b0, 1'b1, 1'b1, 1'b0, E(3, 'h180, 0, 3, 6));
        ph = 7; pc = 3; rem = 36;
        for (int t = 1; t <= 36; t++) begin
            rem--; pc--;
            if (pc == 0) begin
                ph--;
                if (ph >= 0) pc = dur[ph];
            end
            cyc($sformatf("m0_t%0d", t), 1'b0, 1'b0, 1'b0, 1'b1,
                (ph >= 0) ? E(3, 'h100 | (1 << ph), 0, rem / 10, rem % 10) : E(6, 'h100, 0, 0, 0));
        end
        cyc("m0_fin1", 1'b0, 1'b0, 1'b0, 1'b1, E(6, 'h100, 0, 0, 0));
        cyc("m0_fin2", 1'b0, 1'b0, 1'b0, 1'b1, E(6, 'h100, 0, 0, 0));
        cyc("m0_fin3", 1'b0, 1'b0, 1'b0, 1'b1, E(0, 0, 0, 0, 0));

        // Reset mid-run discards all progress
        power_on("rr");
        cyc("rr_mode",  1'b0, 1'b0, 1'b1, 1'b0, E(2, 'h3C0, 1, 1, 2));
        cyc("rr_start", 1'b0, 1'b1, 1'b0, 1'b0, E(3, 'h180, 1, 1, 2));
        cyc("rr_tick",  1'b0, 1'b0, 1'b0, 1'b1, E(3, 'h180, 1, 1, 1));
        @(negedge cp);
        clr();
        rst = 1'b1;
        #1;
        compare("rst_mid", E(0, 0, 0, 0, 0));
        @(negedge cp); rst = 1'b0;
        cyc("rr_stay_off", 1'b0, 1'b1, 1'b1, 1'b1, E(0, 0, 0, 0, 0));
        power_on("rr2");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
